alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
Execute-stage sequencer that drives the shared combinational ALU and collects its result. Accepts decoded-register-read instructions over a valid/ready handshake and translates opcode/funct into the 4-bit ALU control code. Forms the ALU operands (immediate extension, shamt packing), holds mult/div for a multicycle window, then captures result, zero, branch decision and write-back info into an output register with backpressure.

Parameters:
MULDIV_LAT, 4, cycles ALU inputs are held stable for mult/div before capture (legal range 1..15).
ALU_CTRL_W, 4, width of ALU control code (fixed at 4).

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  instruction offered
in_ready  output  1  block accepts instruction this cycle
opcode  input  6  instr[31:26]
funct  input  6  instr[5:0]
shamt  input  5  instr[10:6]
imm  input  16  instr[15:0]
rs_val  input  32  rs register value
rt_val  input  32  rt register value
rt_addr  input  5  rt index
rd_addr  input  5  rd index
alu_a  output  32  ALU operand a (registered)
alu_b  output  32  ALU operand b (registered)
alu_control  output  4  ALU op code (registered)
alu_result  input  32  ALU result (combinational return)
alu_zero  input  1  ALU zero flag
res_valid  output  1  result register holds valid entry
res_ready  input  1  consumer accepts result
res_data  output  32  captured ALU result
branch_taken  output  1  beq/bne taken
wr_en  output  1  write-back required
wr_reg  output  5  destination register

Behaviour:
- Reset (async, rst_n=0): alu_a, alu_b, res_data = 0; alu_control = 4'b0010; res_valid, branch_taken, wr_en = 0; wr_reg = 0; EX state IDLE; counter = 0.
- Decode, R-type (opcode 0): funct 20 add 0010, 22 sub 0110, 24 and 0000, 25 or 0001, 26 xor 0100, 27 nor 1100, 2A slt 0111, 00 sll 1000, 02 srl 1001, 03 sra 1010, 18 mult 0101, 1A div 1011 (funct in hex). a=rs_val, b=rt_val; shifts: a=rt_val, b={21'b0,shamt,6'b0}. wr_reg=rd_addr.
- Decode, I-type: 08 addi 0010, 0A slti 0111, 0C andi 0000, 0D ori 0001, 0E xori 0100, 23 lw 0010, 2B sw 0010, 04 beq 0110, 05 bne 0110 (opcode in hex). a=rs_val; b=sign-ext imm (addi/slti/lw/sw), zero-ext imm (andi/ori/xori), rt_val (beq/bne). wr_reg=rt_addr.
- wr_en=0 for sw, beq, bne; 1 otherwise. branch_taken = alu_zero for beq, !alu_zero for bne, 0 otherwise.
- Illegal opcode/funct: decoded as add, wr_en=0.
- EX FSM: IDLE -> (in_valid&&in_ready) load operands -> BUSY. BUSY: single-cycle ops ready to capture in the first BUSY cycle; mult/div count MULDIV_LAT cycles (counter from 1), ready at count==MULDIV_LAT. At ready, capture into the result register if !res_valid || res_ready, else stall with inputs held stable.
- in_ready = IDLE || (capture this cycle). Back-to-back single-cycle ops give 1 result/cycle; latency in-accept to res_valid = 2 cycles (single-cycle op), MULDIV_LAT+1 cycles (mult/div).
- Result register: res_valid clears on res_ready with no new capture; simultaneous capture and res_ready replaces the entry, res_valid stays 1.
- Operands/control held constant whenever not accepting a new instruction; no combinational path from in_* to alu_*.
- Reset mid-mult: counter, state and result register cleared; the in-flight op is dropped.

Optional Feature:
ALU_ISSUE_TRAP_EN: adds output trap (1 bit, reset 0). Illegal opcode/funct or div with rt_val==0 sets trap with res_valid for that entry; wr_en=0 and branch_taken=0. Div-by-zero is not issued (no hold cycles, captured immediately). Without the macro: no trap port, illegal behaves as above, div-by-zero issued normally with wr_en=1.

Decomposition:
Package alu_issue_pkg: ALU control code constants (ALU_AND..ALU_DIV), opcode/funct constants, EX state encoding. Sub-module alu_op_decode (combinational opcode/funct -> control, operand select, ext mode, wr_en, wr_reg select, is_muldiv, is_branch, illegal).

Test Plan:
add: rs=5, rt=7, funct 20 -> alu_control=0010, a=5, b=7; 2 cycles later res_data=12, wr_en=1, wr_reg=rd.
sll: rt=1, shamt=4 -> a=1, b=32'h100, control 1000; res_data=16.
beq: rs=rt=9 -> control 0110, branch_taken=1, wr_en=0; bne with same values -> branch_taken=0.
mult, MULDIV_LAT=4: 3*4 -> in_ready low for 4 cycles, alu_a/b stable, res_data=12 at cycle 5.
Backpressure: res_ready=0 with two adds queued -> second held in EX, in_ready=0, no data lost; release gives both in order.
andi imm=16'hFFFF, rs=32'h1234_5678 -> b=32'h0000_FFFF, res_data=32'h0000_5678; addi imm=16'hFFFF, rs=1 -> res_data=0.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: ALU control codes, MIPS opcode/funct values and EX-stage encodings.
package alu_issue_pkg;
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_MULT = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b1010;
    localparam logic [3:0] ALU_DIV  = 4'b1011;
    localparam logic [3:0] ALU_NOR  = 4'b1100;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_MULT = 6'h18;
    localparam logic [5:0] F_DIV  = 6'h1A;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;

    typedef enum logic {IDLE, BUSY} ex_state_t;
    typedef enum logic [1:0] {B_RT, B_SEXT, B_ZEXT, B_SHAMT} b_sel_t;
endpackage

// File: rtl/alu_issue_ctrl_decode.sv
// alu_op_decode: combinational opcode/funct to ALU control, operand select and write-back info.
module alu_op_decode
    import alu_issue_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [3:0] ctrl,
    output b_sel_t     b_sel,
    output logic       a_rt,
    output logic       wr_en,
    output logic       wr_rd,
    output logic       is_muldiv,
    output logic       is_branch,
    output logic       is_bne,
    output logic       illegal
);
    always_comb begin
        ctrl = ALU_ADD;
        b_sel = B_RT;
        a_rt = 1'b0;
        wr_en = 1'b1;
        wr_rd = opcode == OP_RTYPE;
        is_muldiv = 1'b0;
        is_branch = 1'b0;
        is_bne = 1'b0;
        illegal = 1'b0;
        if (opcode == OP_RTYPE) begin
            case (funct)
                F_ADD:  ctrl = ALU_ADD;
                F_SUB:  ctrl = ALU_SUB;
                F_AND:  ctrl = ALU_AND;
                F_OR:   ctrl = ALU_OR;
                F_XOR:  ctrl = ALU_XOR;
                F_NOR:  ctrl = ALU_NOR;
                F_SLT:  ctrl = ALU_SLT;
                F_SLL:  begin ctrl = ALU_SLL; a_rt = 1'b1; b_sel = B_SHAMT; end
                F_SRL:  begin ctrl = ALU_SRL; a_rt = 1'b1; b_sel = B_SHAMT; end
                F_SRA:  begin ctrl = ALU_SRA; a_rt = 1'b1; b_sel = B_SHAMT; end
                F_MULT: begin ctrl = ALU_MULT; is_muldiv = 1'b1; end
                F_DIV:  begin ctrl = ALU_DIV; is_muldiv = 1'b1; end
                default: illegal = 1'b1;
            endcase
        end else begin
            case (opcode)
                OP_ADDI: b_sel = B_SEXT;
                OP_SLTI: begin ctrl = ALU_SLT; b_sel = B_SEXT; end
                OP_ANDI: begin ctrl = ALU_AND; b_sel = B_ZEXT; end
                OP_ORI:  begin ctrl = ALU_OR; b_sel = B_ZEXT; end
                OP_XORI: begin ctrl = ALU_XOR; b_sel = B_ZEXT; end
                OP_LW:   b_sel = B_SEXT;
                OP_SW:   begin b_sel = B_SEXT; wr_en = 1'b0; end
                OP_BEQ:  begin ctrl = ALU_SUB; is_branch = 1'b1; wr_en = 1'b0; end
                OP_BNE:  begin ctrl = ALU_SUB; is_branch = 1'b1; is_bne = 1'b1; wr_en = 1'b0; end
                default: illegal = 1'b1;
            endcase
        end
    end
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: execute-stage sequencer driving a shared ALU and registering its result.
// Optional ALU_ISSUE_TRAP_EN adds a trap output for illegal ops and divide-by-zero.
module alu_issue_ctrl
    import alu_issue_pkg::*;
#(
    parameter int MULDIV_LAT = 4,
    parameter int ALU_CTRL_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [5:0]            opcode,
    input  logic [5:0]            funct,
    input  logic [4:0]            shamt,
    input  logic [15:0]           imm,
    input  logic [31:0]           rs_val,
    input  logic [31:0]           rt_val,
    input  logic [4:0]            rt_addr,
    input  logic [4:0]            rd_addr,
    output logic [31:0]           alu_a,
    output logic [31:0]           alu_b,
    output logic [ALU_CTRL_W-1:0] alu_control,
    input  logic [31:0]           alu_result,
    input  logic                  alu_zero,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [31:0]           res_data,
    output logic                  branch_taken,
    output logic                  wr_en,
    output logic [4:0]            wr_reg
`ifdef ALU_ISSUE_TRAP_EN
    ,
    output logic                  trap
`endif
);
    logic [3:0] dec_ctrl;
    b_sel_t     dec_b_sel;
    logic       dec_a_rt, dec_wr_en, dec_wr_rd, dec_muldiv, dec_branch, dec_bne, dec_illegal;
    ex_state_t  state;
    logic [3:0] cnt;
    logic       muldiv_p, wr_en_p, br_p, bne_p;
    logic [4:0] wr_reg_p;
    logic       trap_n, cap_ready, capture, accept;
    logic [31:0] b_next;

    alu_op_decode u_dec (
        .opcode    (opcode),
        .funct     (funct),
        .ctrl      (dec_ctrl),
        .b_sel     (dec_b_sel),
        .a_rt      (dec_a_rt),
        .wr_en     (dec_wr_en),
        .wr_rd     (dec_wr_rd),
        .is_muldiv (dec_muldiv),
        .is_branch (dec_branch),
        .is_bne    (dec_bne),
        .illegal   (dec_illegal)
    );

`ifdef ALU_ISSUE_TRAP_EN
    logic trap_p;
    assign trap_n = dec_illegal || (dec_ctrl == ALU_DIV && rt_val == 32'd0);
`else
    assign trap_n = dec_illegal;
`endif

    assign b_next = dec_b_sel == B_SHAMT ? {21'b0, shamt, 6'b0} :
                    dec_b_sel == B_SEXT  ? {{16{imm[15]}}, imm} :
                    dec_b_sel == B_ZEXT  ? {16'b0, imm} : rt_val;
    assign cap_ready = state == BUSY && (!muldiv_p || cnt == 4'(MULDIV_LAT));
    assign capture = cap_ready && (!res_valid || res_ready);
    assign in_ready = state == IDLE || capture;
    assign accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt <= 4'd0;
            alu_a <= 32'd0;
            alu_b <= 32'd0;
            alu_control <= ALU_ADD;
            muldiv_p <= 1'b0;
            wr_en_p <= 1'b0;
            br_p <= 1'b0;
            bne_p <= 1'b0;
            wr_reg_p <= 5'd0;
            res_valid <= 1'b0;
            res_data <= 32'd0;
            branch_taken <= 1'b0;
            wr_en <= 1'b0;
            wr_reg <= 5'd0;
`ifdef ALU_ISSUE_TRAP_EN
            trap_p <= 1'b0;
            trap <= 1'b0;
`endif
        end else begin
            if (accept) begin
                state <= BUSY;
                cnt <= 4'd1;
                alu_a <= dec_a_rt ? rt_val : rs_val;
                alu_b <= b_next;
                alu_control <= dec_ctrl;
                // a trapped divide skips the hold window and is captured at once
                muldiv_p <= dec_muldiv && !trap_n;
                wr_en_p <= dec_wr_en && !trap_n;
                br_p <= dec_branch;
                bne_p <= dec_bne;
                wr_reg_p <= dec_wr_rd ? rd_addr : rt_addr;
`ifdef ALU_ISSUE_TRAP_EN
                trap_p <= trap_n;
`endif
            end else if (capture) begin
                state <= IDLE;
            end else if (state == BUSY && muldiv_p && cnt != 4'(MULDIV_LAT)) begin
                cnt <= cnt + 4'd1;
            end
            if (capture) begin
                res_valid <= 1'b1;
                res_data <= alu_result;
                branch_taken <= br_p && (alu_zero ^ bne_p);
                wr_en <= wr_en_p;
                wr_reg <= wr_reg_p;
`ifdef ALU_ISSUE_TRAP_EN
                trap <= trap_p;
`endif
            end else if (res_ready) begin
                res_valid <= 1'b0;
`ifdef ALU_ISSUE_TRAP_EN
                trap <= 1'b0;
`endif
            end
        end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed vector table plus multicycle, backpressure and reset sequences.
module tb_alu_issue_ctrl;
    logic        clk, rst_n, in_valid, in_ready, alu_zero, res_valid, res_ready;
    logic        branch_taken, wr_en;
    logic [5:0]  opcode, funct;
    logic [4:0]  shamt, rt_addr, rd_addr, wr_reg;
    logic [15:0] imm;
    logic [31:0] rs_val, rt_val, alu_a, alu_b, alu_result, res_data;
    logic [3:0]  alu_control;
    int          errors = 0;
    int          checks = 0;

    typedef struct {
        logic [5:0]  op, fn;
        logic [4:0]  sh;
        logic [15:0] im;
        logic [31:0] rs, rt;
        logic [4:0]  rta, rda;
        logic [3:0]  ctrl;
        logic [31:0] a, b, res;
        logic        wr;
        logic [4:0]  wreg;
        logic        br;
    } vec_t;

    vec_t v[15];

    alu_issue_ctrl #(.MULDIV_LAT(4), .ALU_CTRL_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct(funct), .shamt(shamt), .imm(imm),
        .rs_val(rs_val), .rt_val(rt_val), .rt_addr(rt_addr), .rd_addr(rd_addr),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .branch_taken(branch_taken), .wr_en(wr_en), .wr_reg(wr_reg)
    );

    // reference ALU standing in for the shared combinational unit
    always_comb begin
        alu_result = 32'd0;
        case (alu_control)
            4'b0000: alu_result = alu_a & alu_b;
            4'b0001: alu_result = alu_a | alu_b;
            4'b0010: alu_result = alu_a + alu_b;
            4'b0100: alu_result = alu_a ^ alu_b;
            4'b0101: alu_result = 32'(alu_a * alu_b);
            4'b0110: alu_result = alu_a - alu_b;
            4'b0111: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
            4'b1000: alu_result = alu_a << alu_b[10:6];
            4'b1001: alu_result = alu_a >> alu_b[10:6];
            4'b1010: alu_result = $signed(alu_a) >>> alu_b[10:6];
            4'b1011: alu_result = alu_b == 32'd0 ? 32'd0 : alu_a / alu_b;
            4'b1100: alu_result = ~(alu_a | alu_b);
            default: alu_result = 32'd0;
        endcase
    end
    assign alu_zero = alu_result == 32'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                         input logic [15:0] im, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [4:0] rta, input logic [4:0] rda);
        in_valid = 1'b1;
        opcode = op;
        funct = fn;
        shamt = sh;
        imm = im;
        rs_val = rs;
        rt_val = rt;
        rt_addr = rta;
        rd_addr = rda;
    endtask

    task automatic wait_res(input string name);
        int n;
        n = 0;
        while (!res_valid && n < 40) begin
            tick();
            n++;
        end
        if (!res_valid) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: res_valid %b after %0d cycles, required 1", name, res_valid, n);
        end
    endtask

    initial begin
        //            op     fn     sh     imm       rs            rt            rta    rda    ctrl     a             b             res           wr    wreg   br
        v[0]  = '{6'h00, 6'h20, 5'd0,  16'h0000, 32'd5,        32'd7,        5'd2,  5'd3,  4'b0010, 32'd5,        32'd7,        32'd12,       1'b1, 5'd3,  1'b0};
        v[1]  = '{6'h00, 6'h00, 5'd4,  16'h0000, 32'd99,       32'd1,        5'd2,  5'd9,  4'b1000, 32'd1,        32'h100,      32'd16,       1'b1, 5'd9,  1'b0};
        v[2]  = '{6'h04, 6'h00, 5'd0,  16'h0010, 32'd9,        32'd9,        5'd4,  5'd1,  4'b0110, 32'd9,        32'd9,        32'd0,        1'b0, 5'd4,  1'b1};
        v[3]  = '{6'h05, 6'h00, 5'd0,  16'h0010, 32'd9,        32'd9,        5'd4,  5'd1,  4'b0110, 32'd9,        32'd9,        32'd0,        1'b0, 5'd4,  1'b0};
        v[4]  = '{6'h0C, 6'h00, 5'd0,  16'hFFFF, 32'h12345678, 32'd0,        5'd6,  5'd1,  4'b0000, 32'h12345678, 32'h0000FFFF, 32'h00005678, 1'b1, 5'd6,  1'b0};
        v[5]  = '{6'h08, 6'h00, 5'd0,  16'hFFFF, 32'd1,        32'd0,        5'd7,  5'd1,  4'b0010, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b1, 5'd7,  1'b0};
        v[6]  = '{6'h00, 6'h22, 5'd0,  16'h0000, 32'd3,        32'd5,        5'd2,  5'd10, 4'b0110, 32'd3,        32'd5,        32'hFFFFFFFE, 1'b1, 5'd10, 1'b0};
        v[7]  = '{6'h00, 6'h2A, 5'd0,  16'h0000, 32'hFFFFFFFF, 32'd1,        5'd2,  5'd11, 4'b0111, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b1, 5'd11, 1'b0};
        v[8]  = '{6'h2B, 6'h00, 5'd0,  16'h0004, 32'd100,      32'd55,       5'd8,  5'd1,  4'b0010, 32'd100,      32'd4,        32'd104,      1'b0, 5'd8,  1'b0};
        v[9]  = '{6'h3F, 6'h00, 5'd0,  16'h0000, 32'd20,       32'd22,       5'd12, 5'd1,  4'b0010, 32'd20,       32'd22,       32'd42,       1'b0, 5'd12, 1'b0};
        v[10] = '{6'h00, 6'h03, 5'd4,  16'h0000, 32'd0,        32'h80000000, 5'd2,  5'd13, 4'b1010, 32'h80000000, 32'h100,      32'hF8000000, 1'b1, 5'd13, 1'b0};
        v[11] = '{6'h00, 6'h27, 5'd0,  16'h0000, 32'd0,        32'hFFFF0000, 5'd2,  5'd14, 4'b1100, 32'd0,        32'hFFFF0000, 32'h0000FFFF, 1'b1, 5'd14, 1'b0};
        v[12] = '{6'h00, 6'h1A, 5'd0,  16'h0000, 32'd20,       32'd3,        5'd2,  5'd15, 4'b1011, 32'd20,       32'd3,        32'd6,        1'b1, 5'd15, 1'b0};
        v[13] = '{6'h0E, 6'h00, 5'd0,  16'h8000, 32'hFFFFFFFF, 32'd0,        5'd16, 5'd1,  4'b0100, 32'hFFFFFFFF, 32'h00008000, 32'hFFFF7FFF, 1'b1, 5'd16, 1'b0};
        v[14] = '{6'h00, 6'h02, 5'd31, 16'h0000, 32'd0,        32'h80000000, 5'd2,  5'd17, 4'b1001, 32'h80000000, 32'h7C0,      32'd1,        1'b1, 5'd17, 1'b0};

        rst_n = 1'b0;
        res_ready = 1'b1;
        in_valid = 1'b0;
        drive(6'h00, 6'h20, 5'd0, 16'h0, 32'd0, 32'd0, 5'd0, 5'd0);
        in_valid = 1'b0;
        tick();
        tick();
        chk("rst alu_control", 32'(alu_control), 32'h2);
        chk("rst alu_a", alu_a, 32'd0);
        chk("rst res_valid", 32'(res_valid), 32'd0);
        chk("rst in_ready", 32'(in_ready), 32'd1);
        chk("rst res_data", res_data, 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 15; i++) begin
            drive(v[i].op, v[i].fn, v[i].sh, v[i].im, v[i].rs, v[i].rt, v[i].rta, v[i].rda);
            tick();
            in_valid = 1'b0;
            chk($sformatf("v%0d alu_control", i), 32'(alu_control), 32'(v[i].ctrl));
            chk($sformatf("v%0d alu_a", i), alu_a, v[i].a);
            chk($sformatf("v%0d alu_b", i), alu_b, v[i].b);
            wait_res($sformatf("v%0d", i));
            chk($sformatf("v%0d res_data", i), res_data, v[i].res);
            chk($sformatf("v%0d wr_en", i), 32'(wr_en), 32'(v[i].wr));
            chk($sformatf("v%0d wr_reg", i), 32'(wr_reg), 32'(v[i].wreg));
            chk($sformatf("v%0d branch_taken", i), 32'(branch_taken), 32'(v[i].br));
            tick();
            chk($sformatf("v%0d res_valid clear", i), 32'(res_valid), 32'd0);
        end

        // mult 3*4 holds operands for the full window, result visible 5 cycles after accept
        drive(6'h00, 6'h18, 5'd0, 16'h0, 32'd3, 32'd4, 5'd2, 5'd5);
        tick();
        in_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            chk($sformatf("mult c%0d in_ready", k), 32'(in_ready), 32'd0);
            chk($sformatf("mult c%0d alu_a", k), alu_a, 32'd3);
            chk($sformatf("mult c%0d alu_b", k), alu_b, 32'd4);
            chk($sformatf("mult c%0d res_valid", k), 32'(res_valid), 32'd0);
            tick();
        end
        chk("mult c4 res_valid", 32'(res_valid), 32'd0);
        chk("mult c4 in_ready", 32'(in_ready), 32'd1);
        tick();
        chk("mult c5 res_valid", 32'(res_valid), 32'd1);
        chk("mult c5 res_data", res_data, 32'd12);
        tick();

        // backpressure: second add waits in EX, third offered but refused until release
        res_ready = 1'b0;
        drive(6'h00, 6'h20, 5'd0, 16'h0, 32'd1, 32'd1, 5'd2, 5'd3);
        tick();
        drive(6'h00, 6'h20, 5'd0, 16'h0, 32'd2, 32'd2, 5'd2, 5'd4);
        tick();
        drive(6'h00, 6'h20, 5'd0, 16'h0, 32'd5, 32'd5, 5'd2, 5'd6);
        chk("bp first res_data", res_data, 32'd2);
        chk("bp first res_valid", 32'(res_valid), 32'd1);
        for (int k = 0; k < 2; k++) begin
            tick();
            chk($sformatf("bp stall%0d in_ready", k), 32'(in_ready), 32'd0);
            chk($sformatf("bp stall%0d res_data", k), res_data, 32'd2);
            chk($sformatf("bp stall%0d alu_a", k), alu_a, 32'd2);
        end
        res_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("bp second res_data", res_data, 32'd4);
        chk("bp second wr_reg", 32'(wr_reg), 32'd4);
        chk("bp second res_valid", 32'(res_valid), 32'd1);
        tick();
        chk("bp third res_data", res_data, 32'd10);
        chk("bp third res_valid", 32'(res_valid), 32'd1);
        tick();
        chk("bp drained res_valid", 32'(res_valid), 32'd0);

        // async reset in the middle of a mult drops it
        drive(6'h00, 6'h18, 5'd0, 16'h0, 32'd6, 32'd7, 5'd2, 5'd5);
        tick();
        in_valid = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst in_ready", 32'(in_ready), 32'd1);
        chk("midrst alu_control", 32'(alu_control), 32'h2);
        chk("midrst alu_a", alu_a, 32'd0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        chk("midrst no result", 32'(res_valid), 32'd0);
        chk("midrst res_data", res_data, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
